trap_controller: RTL and testbench

Trap request side of the privilege machinery. Collects synchronous exceptions from the pipeline and the machine-level software, timer and external interrupt lines, and gates interrupts by `mie` and `mstatus.MIE`/privilege. It sequences a pipeline flush handshake, then emits the one-cycle one-hot `trapTrigger` consumed by `core_status`. In the same cycle it writes `mcause`/`mepc`/`mtval` and issues the redirect PC from `mtvec`.

---
 rtl/trap_controller_pkg.sv | 19 +
 rtl/trap_controller_priority_enc.sv | 44 ++++
 rtl/trap_controller.sv | 185 ++++++++++++++++++
 tb/tb_trap_controller.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trap_controller_pkg.sv
// Shared types and constants for the machine-mode trap request logic.
package trap_controller_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StFlush,
        StCommit
    } trap_state_t;

    localparam logic [3:0] IRQ_SOFT_CODE  = 4'd3;
    localparam logic [3:0] IRQ_TIMER_CODE = 4'd7;
    localparam logic [3:0] IRQ_EXT_CODE   = 4'd11;

    localparam int unsigned MSTATUS_MIE = 3;

    localparam logic [1:0] MTVEC_DIRECT   = 2'd0;
    localparam logic [1:0] MTVEC_VECTORED = 2'd1;

endpackage

// File: rtl/trap_controller_priority_enc.sv
// Picks the winning trap cause: synchronous exceptions first, then
// enabled interrupts in the order external, software, timer.
module trap_controller_priority_enc
    import trap_controller_pkg::*;
#(
    parameter int unsigned N = 64
) (
    input  logic         exc_valid_i,
    input  logic [3:0]   exc_code_i,
    input  logic [N-1:0] int_pend_i,
    input  logic         int_en_i,
    output logic         valid_o,
    output logic [3:0]   code_o,
    output logic         is_int_o
);

    logic unused_pend;
    assign unused_pend = ^int_pend_i;

    always_comb begin
        valid_o  = 1'b0;
        code_o   = 4'd0;
        is_int_o = 1'b0;
        if (exc_valid_i) begin
            valid_o = 1'b1;
            code_o  = exc_code_i;
        end else if (int_en_i) begin
            if (int_pend_i[IRQ_EXT_CODE]) begin
                valid_o  = 1'b1;
                code_o   = IRQ_EXT_CODE;
                is_int_o = 1'b1;
            end else if (int_pend_i[IRQ_SOFT_CODE]) begin
                valid_o  = 1'b1;
                code_o   = IRQ_SOFT_CODE;
                is_int_o = 1'b1;
            end else if (int_pend_i[IRQ_TIMER_CODE]) begin
                valid_o  = 1'b1;
                code_o   = IRQ_TIMER_CODE;
                is_int_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/trap_controller.sv
// Trap sequencer: latch cause, handshake a pipeline flush, then commit the trap CSRs
// and redirect fetch. Define TRAP_VECTORED_EN for vectored interrupt dispatch via mtvec.
module trap_controller
    import trap_controller_pkg::*;
#(
    parameter int unsigned N = 64
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         exc_valid_i,
    input  logic [3:0]   exc_code_i,
    input  logic [N-1:0] exc_pc_i,
    input  logic [N-1:0] exc_tval_i,
    input  logic [N-1:0] next_pc_i,
    input  logic         irq_soft_i,
    input  logic         irq_timer_i,
    input  logic         irq_ext_i,
    input  logic [N-1:0] mstatus_i,
    input  logic [1:0]   current_mode_i,
    input  logic [N-1:0] csr_in_i,
    input  logic         mie_write_i,
    input  logic         mtvec_write_i,
    input  logic         flush_ack_i,
    output logic         flush_req_o,
    output logic [15:0]  trap_trigger_o,
    output logic         redirect_valid_o,
    output logic [N-1:0] trap_target_o,
    output logic [N-1:0] mcause_o,
    output logic [N-1:0] mepc_o,
    output logic [N-1:0] mtval_o,
    output logic [N-1:0] mie_o,
    output logic [N-1:0] mip_o,
    output logic [N-1:0] mtvec_o
);

    trap_state_t  state_q, state_d;
    logic [3:0]   code_q, code_d;
    logic         is_int_q, is_int_d;
    logic [N-1:0] epc_q, epc_d;
    logic [N-1:0] tval_q, tval_d;
    logic [N-1:0] mcause_q, mcause_d;
    logic [N-1:0] mepc_q, mepc_d;
    logic [N-1:0] mtval_q, mtval_d;
    logic [N-1:0] mie_q, mie_d;
    logic [N-1:0] mip_q, mip_d;
    logic [N-1:0] mtvec_q, mtvec_d;

    logic         int_en;
    logic         pr_valid;
    logic [3:0]   pr_code;
    logic         pr_is_int;
    logic [N-1:0] base_addr;
    logic [N-1:0] target;

    logic unused_bits;
    assign unused_bits = ^{mstatus_i, csr_in_i[1:0]};

    assign int_en = (current_mode_i != 2'b11) | mstatus_i[MSTATUS_MIE];

    trap_controller_priority_enc #(
        .N(N)
    ) u_prio (
        .exc_valid_i(exc_valid_i),
        .exc_code_i (exc_code_i),
        .int_pend_i (mip_q & mie_q),
        .int_en_i   (int_en),
        .valid_o    (pr_valid),
        .code_o     (pr_code),
        .is_int_o   (pr_is_int)
    );

    assign base_addr = {mtvec_q[N-1:2], 2'b00};

`ifdef TRAP_VECTORED_EN
    assign target = (is_int_q && (mtvec_q[1:0] == MTVEC_VECTORED)) ?
                    base_addr + {{(N-6){1'b0}}, code_q, 2'b00} : base_addr;
`else
    assign target = base_addr;
`endif

    always_comb begin
        mip_d = '0;
        mip_d[IRQ_SOFT_CODE]  = irq_soft_i;
        mip_d[IRQ_TIMER_CODE] = irq_timer_i;
        mip_d[IRQ_EXT_CODE]   = irq_ext_i;

        mie_d = mie_q;
        if (mie_write_i) begin
            mie_d = '0;
            mie_d[IRQ_SOFT_CODE]  = csr_in_i[IRQ_SOFT_CODE];
            mie_d[IRQ_TIMER_CODE] = csr_in_i[IRQ_TIMER_CODE];
            mie_d[IRQ_EXT_CODE]   = csr_in_i[IRQ_EXT_CODE];
        end

        mtvec_d = mtvec_q;
        if (mtvec_write_i) begin
`ifdef TRAP_VECTORED_EN
            // Reserved modes 2/3 collapse to direct.
            mtvec_d = {csr_in_i[N-1:2],
                       (csr_in_i[1:0] == MTVEC_VECTORED) ? MTVEC_VECTORED : MTVEC_DIRECT};
`else
            mtvec_d = {csr_in_i[N-1:2], MTVEC_DIRECT};
`endif
        end
    end

    always_comb begin
        state_d          = state_q;
        code_d           = code_q;
        is_int_d         = is_int_q;
        epc_d            = epc_q;
        tval_d           = tval_q;
        mcause_d         = mcause_q;
        mepc_d           = mepc_q;
        mtval_d          = mtval_q;
        flush_req_o      = 1'b0;
        trap_trigger_o   = '0;
        redirect_valid_o = 1'b0;
        trap_target_o    = '0;

        unique case (state_q)
            StIdle: begin
                if (pr_valid) begin
                    code_d   = pr_code;
                    is_int_d = pr_is_int;
                    epc_d    = pr_is_int ? next_pc_i : exc_pc_i;
                    tval_d   = pr_is_int ? '0 : exc_tval_i;
                    state_d  = StFlush;
                end
            end
            StFlush: begin
                flush_req_o = 1'b1;
                if (flush_ack_i) begin
                    state_d = StCommit;
                end
            end
            StCommit: begin
                trap_trigger_o[code_q] = 1'b1;
                redirect_valid_o       = 1'b1;
                trap_target_o          = target;
                mcause_d               = {is_int_q, {(N-5){1'b0}}, code_q};
                mepc_d                 = {epc_q[N-1:1], 1'b0};
                mtval_d                = tval_q;
                state_d                = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            code_q   <= '0;
            is_int_q <= 1'b0;
            epc_q    <= '0;
            tval_q   <= '0;
            mcause_q <= '0;
            mepc_q   <= '0;
            mtval_q  <= '0;
            mie_q    <= '0;
            mip_q    <= '0;
            mtvec_q  <= '0;
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            is_int_q <= is_int_d;
            epc_q    <= epc_d;
            tval_q   <= tval_d;
            mcause_q <= mcause_d;
            mepc_q   <= mepc_d;
            mtval_q  <= mtval_d;
            mie_q    <= mie_d;
            mip_q    <= mip_d;
            mtvec_q  <= mtvec_d;
        end
    end

    assign mcause_o = mcause_q;
    assign mepc_o   = mepc_q;
    assign mtval_o  = mtval_q;
    assign mie_o    = mie_q;
    assign mip_o    = mip_q;
    assign mtvec_o  = mtvec_q;

endmodule

// File: tb/tb_trap_controller.sv
// Randomized self-checking bench for trap_controller against a cause/priority reference model.
module tb_trap_controller;

    localparam int unsigned N = 64;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         exc_valid = 1'b0;
    logic [3:0]   exc_code = '0;
    logic [N-1:0] exc_pc = '0, exc_tval = '0, next_pc = '0;
    logic         irq_soft = 1'b0, irq_timer = 1'b0, irq_ext = 1'b0;
    logic [N-1:0] mstatus = '0;
    logic [1:0]   current_mode = 2'b11;
    logic [N-1:0] csr_in = '0;
    logic         mie_write = 1'b0, mtvec_write = 1'b0, flush_ack = 1'b0;
    logic         flush_req, redirect_valid;
    logic [15:0]  trap_trigger;
    logic [N-1:0] trap_target, mcause, mepc, mtval, mie, mip, mtvec;

    always #5 clk = ~clk;

    trap_controller #(.N(N)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .exc_valid_i     (exc_valid),
        .exc_code_i      (exc_code),
        .exc_pc_i        (exc_pc),
        .exc_tval_i      (exc_tval),
        .next_pc_i       (next_pc),
        .irq_soft_i      (irq_soft),
        .irq_timer_i     (irq_timer),
        .irq_ext_i       (irq_ext),
        .mstatus_i       (mstatus),
        .current_mode_i  (current_mode),
        .csr_in_i        (csr_in),
        .mie_write_i     (mie_write),
        .mtvec_write_i   (mtvec_write),
        .flush_ack_i     (flush_ack),
        .flush_req_o     (flush_req),
        .trap_trigger_o  (trap_trigger),
        .redirect_valid_o(redirect_valid),
        .trap_target_o   (trap_target),
        .mcause_o        (mcause),
        .mepc_o          (mepc),
        .mtval_o         (mtval),
        .mie_o           (mie),
        .mip_o           (mip),
        .mtvec_o         (mtvec)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [N-1:0] mie_m = '0;
    logic [N-1:0] mtvec_m = '0;

    // Observation results of the latest trap sequence.
    int           o_req_lat, o_flush_cnt, o_trig_lat, o_trig_cnt;
    logic [15:0]  o_trig;
    logic [N-1:0] o_tgt, o_cause, o_epc, o_tval;
    logic         o_redir;

    function automatic logic [N-1:0] mtvec_model(input logic [N-1:0] v);
`ifdef TRAP_VECTORED_EN
        return {v[N-1:2], (v[1:0] == 2'b01) ? 2'b01 : 2'b00};
`else
        return {v[N-1:2], 2'b00};
`endif
    endfunction

    function automatic logic [N-1:0] target_model(input logic [N-1:0] tv, input int code,
                                                  input bit is_int);
        logic [N-1:0] base;
        base = tv & ~64'h3;
`ifdef TRAP_VECTORED_EN
        if (is_int && tv[1:0] == 2'b01) return base + 64'(4 * code);
`endif
        return base;
    endfunction

    function automatic logic [N-1:0] cause_model(input int code, input bit is_int);
        return (is_int ? 64'h8000_0000_0000_0000 : 64'h0) | 64'(code);
    endfunction

    // lines = {ext, timer, soft}; returns -1 when no interrupt is taken.
    function automatic int irq_model(input logic [2:0] lines, input logic [N-1:0] en,
                                     input logic [1:0] md, input logic gie);
        int prio [3] = '{11, 3, 7};
        logic [N-1:0] pend;
        pend = '0;
        pend[3]  = lines[0];
        pend[7]  = lines[1];
        pend[11] = lines[2];
        pend = pend & en;
        if (md == 2'b11 && !gie) return -1;
        foreach (prio[k]) if (pend[prio[k]]) return prio[k];
        return -1;
    endfunction

    task automatic csr_write(input bit is_mtvec, input logic [N-1:0] v);
        csr_in = v;
        if (is_mtvec) mtvec_write = 1'b1;
        else mie_write = 1'b1;
        @(posedge clk); #1;
        mie_write = 1'b0;
        mtvec_write = 1'b0;
        if (is_mtvec) mtvec_m = mtvec_model(v);
        else mie_m = v & 64'h888;
    endtask

    // Called in the cycle a request is presented; runs the flush handshake with ack after
    // ack_delay low cycles and records what the DUT did until the cycle after commit.
    task automatic observe(input int ack_delay, input bit clr_irq, input bit cmt_wr,
                           input logic [N-1:0] cmt_val);
        o_req_lat = -1; o_flush_cnt = 0; o_trig_lat = -1; o_trig_cnt = 0;
        o_trig = '0; o_tgt = '0; o_redir = 1'b0; o_cause = '0; o_epc = '0; o_tval = '0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            exc_valid = 1'b0;
            mtvec_write = 1'b0;
            if (clr_irq && i == 1) {irq_ext, irq_timer, irq_soft} = 3'b000;
            if (o_trig_lat >= 0) begin
                if (trap_trigger != 16'h0) o_trig_cnt++;
                o_cause = mcause; o_epc = mepc; o_tval = mtval;
                break;
            end
            flush_ack = 1'b0;
            if (flush_req) begin
                if (o_req_lat < 0) o_req_lat = i;
                o_flush_cnt++;
                if (o_flush_cnt == ack_delay + 1) flush_ack = 1'b1;
            end
            if (trap_trigger != 16'h0) begin
                o_trig_lat = i; o_trig_cnt++; o_trig = trap_trigger;
                o_tgt = trap_target; o_redir = redirect_valid;
                if (cmt_wr) begin
                    csr_in = cmt_val;
                    mtvec_write = 1'b1;
                end
            end
        end
        flush_ack = 1'b0;
    endtask

    // Applies a synchronous exception and checks the complete trap against the model.
    task automatic run_exception(input string tag, input int code, input logic [N-1:0] pc,
                                 input logic [N-1:0] tv, input int ack_delay);
        logic [15:0]  e_trig;
        logic [N-1:0] e_tgt;
        e_trig = 16'h1 << code;
        e_tgt  = target_model(mtvec_m, code, 1'b0);
        exc_valid = 1'b1; exc_code = 4'(code); exc_pc = pc; exc_tval = tv;
        observe(ack_delay, 1'b0, 1'b0, '0);
        n_vec++; if (o_req_lat !== 1) begin n_err++;
            $display("FAIL %s req_lat: got %0d want 1", tag, o_req_lat); end
        n_vec++; if (o_flush_cnt !== ack_delay + 1) begin n_err++;
            $display("FAIL %s flush_cycles: got %0d want %0d", tag, o_flush_cnt, ack_delay + 1);
        end
        n_vec++; if (o_trig_lat !== ack_delay + 2) begin n_err++;
            $display("FAIL %s trig_lat: got %0d want %0d", tag, o_trig_lat, ack_delay + 2); end
        n_vec++; if (o_trig_cnt !== 1) begin n_err++;
            $display("FAIL %s trig_pulses: got %0d want 1", tag, o_trig_cnt); end
        n_vec++; if (o_trig !== e_trig || o_redir !== 1'b1) begin n_err++;
            $display("FAIL %s trigger: got %h/%b want %h/1", tag, o_trig, o_redir, e_trig); end
        n_vec++; if (o_tgt !== e_tgt) begin n_err++;
            $display("FAIL %s target: got %h want %h", tag, o_tgt, e_tgt); end
        n_vec++; if (o_cause !== cause_model(code, 1'b0)) begin n_err++;
            $display("FAIL %s mcause: got %h want %h", tag, o_cause, cause_model(code, 1'b0));
        end
        n_vec++; if (o_epc !== (pc & ~64'h1) || o_tval !== tv) begin n_err++;
            $display("FAIL %s mepc/mtval: got %h/%h want %h/%h", tag, o_epc, o_tval,
                     pc & ~64'h1, tv); end
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        n_vec++;
        if ({flush_req, trap_trigger, redirect_valid} !== 18'h0 ||
            {trap_target, mcause, mepc, mtval, mie, mip, mtvec} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got req=%b trig=%h redir=%b cause=%h mtvec=%h want 0",
                     flush_req, trap_trigger, redirect_valid, mcause, mtvec);
        end
        #3 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_csr();
        logic [N-1:0] v;
        logic [2:0]   lines;
        logic [N-1:0] e_mip;
        for (int it = 0; it < 4; it++) begin
            v = {$urandom, $urandom};
            csr_write(1'b0, v);
            n_vec++; if (mie !== (v & 64'h888)) begin n_err++;
                $display("FAIL mie_write: got %h want %h", mie, v & 64'h888); end
            v = {$urandom, $urandom};
            v[1:0] = 2'(it);
            csr_write(1'b1, v);
            n_vec++; if (mtvec !== mtvec_model(v)) begin n_err++;
                $display("FAIL mtvec_write: got %h want %h", mtvec, mtvec_model(v)); end
        end
        csr_write(1'b0, '0);
        for (int it = 0; it < 4; it++) begin
            lines = 3'($urandom);
            {irq_ext, irq_timer, irq_soft} = lines;
            e_mip = (lines[0] ? 64'h8 : 64'h0) | (lines[1] ? 64'h80 : 64'h0) |
                    (lines[2] ? 64'h800 : 64'h0);
            @(posedge clk); #1;
            n_vec++; if (mip !== e_mip || flush_req !== 1'b0) begin n_err++;
                $display("FAIL mip: got %h req=%b want %h req=0", mip, flush_req, e_mip); end
        end
        {irq_ext, irq_timer, irq_soft} = 3'b000;
        @(posedge clk); #1;
    endtask

    task automatic test_exception();
        run_exception("exc_directed", 2, 64'h80, 64'hDEAD, 0);
        for (int it = 0; it < 8; it++) begin
            run_exception("exc_random", int'($urandom_range(15, 0)), {$urandom, $urandom},
                          {$urandom, $urandom}, int'($urandom_range(3, 0)));
        end
    endtask

    task automatic test_interrupt();
        logic [2:0]   lines;
        logic [1:0]   md;
        logic         gie;
        int           ec;
        logic [N-1:0] npc;
        // Timer pending in M-mode with global enable clear: must stay silent.
        csr_write(1'b0, 64'h80);
        current_mode = 2'b11; mstatus = '0; irq_timer = 1'b1; next_pc = 64'h4001_2345;
        observe(0, 1'b0, 1'b0, '0);
        n_vec++; if (o_req_lat !== -1) begin n_err++;
            $display("FAIL irq_gated: got req_lat %0d want none", o_req_lat); end
        mstatus = 64'h8;
        observe(0, 1'b1, 1'b0, '0);
        n_vec++; if (o_trig !== 16'h0080 || o_req_lat !== 1 || o_trig_cnt !== 1) begin
            n_err++;
            $display("FAIL irq_timer: got trig=%h lat=%0d want 0080 lat=1", o_trig, o_req_lat);
        end
        n_vec++; if (o_cause !== 64'h8000_0000_0000_0007 || o_epc !== 64'h4001_2344 ||
                     o_tval !== '0) begin n_err++;
            $display("FAIL irq_timer_csr: got %h/%h/%h want 8000000000000007/%h/0",
                     o_cause, o_epc, o_tval, 64'h4001_2344); end
        for (int it = 0; it < 12; it++) begin
            lines = 3'($urandom); md = 2'($urandom); gie = 1'($urandom);
            csr_write(1'b0, {$urandom, $urandom});
            current_mode = md;
            mstatus = {$urandom, $urandom}; mstatus[3] = gie;
            npc = {$urandom, $urandom}; next_pc = npc;
            {irq_ext, irq_timer, irq_soft} = lines;
            ec = irq_model(lines, mie_m, md, gie);
            observe(int'($urandom_range(2, 0)), 1'b1, 1'b0, '0);
            if (ec < 0) begin
                n_vec++; if (o_req_lat !== -1) begin n_err++;
                    $display("FAIL irq_none: got req_lat %0d want none (lines=%b mie=%h)",
                             o_req_lat, lines, mie_m); end
            end else begin
                n_vec++; if (o_req_lat !== 2 || o_trig !== (16'h1 << ec) || o_trig_cnt !== 1)
                begin n_err++;
                    $display("FAIL irq_rand: got lat=%0d trig=%h want lat=2 trig=%h",
                             o_req_lat, o_trig, 16'h1 << ec); end
                n_vec++; if (o_cause !== cause_model(ec, 1'b1) || o_epc !== (npc & ~64'h1) ||
                             o_tval !== '0 || o_tgt !== target_model(mtvec_m, ec, 1'b1)) begin
                    n_err++;
                    $display("FAIL irq_rand_csr: got %h/%h/%h tgt=%h want %h/%h/0 tgt=%h",
                             o_cause, o_epc, o_tval, o_tgt, cause_model(ec, 1'b1),
                             npc & ~64'h1, target_model(mtvec_m, ec, 1'b1)); end
            end
        end
        current_mode = 2'b11; mstatus = 64'h8;
    endtask

    task automatic test_priority();
        csr_write(1'b0, 64'h800);
        next_pc = 64'h9000_0000;
        irq_ext = 1'b1;
        run_exception("prio_exc", 5, 64'h2000, 64'h77, 1);
        observe(0, 1'b1, 1'b0, '0);
        n_vec++; if (o_req_lat !== 1 || o_trig !== 16'h0800 || o_trig_cnt !== 1) begin
            n_err++;
            $display("FAIL prio_followup: got lat=%0d trig=%h want lat=1 trig=0800",
                     o_req_lat, o_trig); end
        n_vec++; if (o_cause !== cause_model(11, 1'b1) || o_epc !== 64'h9000_0000) begin
            n_err++;
            $display("FAIL prio_followup_csr: got %h/%h want %h/90000000", o_cause, o_epc,
                     cause_model(11, 1'b1)); end
        csr_write(1'b0, '0);
    endtask

    task automatic test_long_flush();
        run_exception("long_flush", 13, 64'h1234_5679, 64'hCAFE, 5);
    endtask

    task automatic test_vectored();
        logic [N-1:0] e_tgt, e_mtvec;
`ifdef TRAP_VECTORED_EN
        e_tgt = 64'h100C; e_mtvec = 64'h1001;
`else
        e_tgt = 64'h1000; e_mtvec = 64'h1000;
`endif
        csr_write(1'b1, 64'h1001);
        csr_write(1'b0, 64'h8);
        n_vec++; if (mtvec !== e_mtvec) begin n_err++;
            $display("FAIL vec_mtvec: got %h want %h", mtvec, e_mtvec); end
        irq_soft = 1'b1;
        observe(0, 1'b1, 1'b0, '0);
        n_vec++; if (o_tgt !== e_tgt || o_trig !== 16'h0008) begin n_err++;
            $display("FAIL vec_target: got %h trig=%h want %h trig=0008", o_tgt, o_trig, e_tgt);
        end
        csr_write(1'b0, '0);
    endtask

    task automatic test_commit_write();
        logic [N-1:0] old_tv, new_tv;
        old_tv = mtvec_m;
        new_tv = {$urandom, $urandom};
        exc_valid = 1'b1; exc_code = 4'd8; exc_pc = 64'h3000; exc_tval = 64'h0;
        observe(1, 1'b0, 1'b1, new_tv);
        mtvec_m = mtvec_model(new_tv);
        n_vec++; if (o_tgt !== target_model(old_tv, 8, 1'b0)) begin n_err++;
            $display("FAIL commit_wr_target: got %h want %h", o_tgt,
                     target_model(old_tv, 8, 1'b0)); end
        n_vec++; if (mtvec !== mtvec_m) begin n_err++;
            $display("FAIL commit_wr_mtvec: got %h want %h", mtvec, mtvec_m); end
    endtask

    task automatic test_reset_mid_flush();
        exc_valid = 1'b1; exc_code = 4'd3; exc_pc = 64'h5550; exc_tval = 64'h1;
        @(posedge clk); #1;
        exc_valid = 1'b0;
        @(posedge clk); #1;
        n_vec++; if (flush_req !== 1'b1) begin n_err++;
            $display("FAIL rst_pre_flush: got req=%b want 1", flush_req); end
        #2 rst = 1'b1;
        #1;
        n_vec++; if ({flush_req, trap_trigger, redirect_valid} !== 18'h0 ||
                     {mcause, mepc, mtval, mie, mtvec} !== '0) begin n_err++;
            $display("FAIL rst_mid_flush: got req=%b trig=%h redir=%b cause=%h epc=%h want 0",
                     flush_req, trap_trigger, redirect_valid, mcause, mepc); end
        @(posedge clk); #1;
        n_vec++; if ({flush_req, trap_trigger, redirect_valid} !== 18'h0) begin n_err++;
            $display("FAIL rst_held: got req=%b trig=%h want 0", flush_req, trap_trigger); end
        #3 rst = 1'b0;
        mtvec_m = '0; mie_m = '0;
        @(posedge clk); #1;
        run_exception("post_reset", 1, 64'h6000, 64'h42, 0);
    endtask

    initial begin
        test_reset();
        test_csr();
        test_exception();
        test_interrupt();
        test_priority();
        test_long_flush();
        test_vectored();
        test_commit_write();
        test_reset_mid_flush();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
